// File: rtl/npc_rf_pkg.sv
// Shared widths and types for the NPC integer register file.
package npc_rf_pkg;

    localparam int unsigned XLEN     = 64;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned AW       = $clog2(NUM_REGS);

    localparam logic [XLEN-1:0] ZERO_WORD = '0;

    typedef struct packed {
        logic            valid;
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rf_wb_select.sv
// Priority match of all write-back ports against one register address.
// The highest-index matching port wins.
module rf_wb_select #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned AW     = 5,
    parameter int unsigned NUM_WB = 2
) (
    input  logic [NUM_WB-1:0]      wb_valid,
    input  logic [NUM_WB*AW-1:0]   wb_addr,
    input  logic [NUM_WB*XLEN-1:0] wb_data,
    input  logic [AW-1:0]          match_addr,
    output logic                   hit,
    output logic [XLEN-1:0]        data
);

    always_comb begin
        hit  = 1'b0;
        data = '0;
        // Ascending scan: a later (higher-index) match overrides an earlier one.
        for (int k = 0; k < int'(NUM_WB); k++) begin
            if (wb_valid[k] && (wb_addr[k*AW +: AW] == match_addr)) begin
                hit  = 1'b1;
                data = wb_data[k*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with write-back bypass, busy scoreboard
// and a registered difftest snapshot.
module regfile_mp_sb
    import npc_rf_pkg::*;
#(
    parameter int unsigned XLEN     = npc_rf_pkg::XLEN,
    parameter int unsigned NUM_REGS = npc_rf_pkg::NUM_REGS,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WB   = 2,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned AW       = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*XLEN-1:0]   rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     iss_valid,
    input  logic [AW-1:0]            iss_rd,
    input  logic [NUM_WB-1:0]        wb_valid,
    input  logic [NUM_WB*AW-1:0]     wb_addr,
    input  logic [NUM_WB*XLEN-1:0]   wb_data,
    output logic [NUM_REGS-1:0]      busy_vec,
    output logic [NUM_REGS*XLEN-1:0] o_reg_difftest
);

    logic [NUM_REGS-1:0][XLEN-1:0] regs_q, regs_d, snap_q;
    logic [NUM_REGS-1:0]           busy_q, busy_d;

    for (genvar r = 0; r < int'(NUM_REGS); r++) begin : g_entry
        if (r == 0) begin : g_zero
            assign regs_d[r] = '0;
            assign busy_d[r] = 1'b0;
        end else begin : g_reg
            logic            wb_hit;
            logic [XLEN-1:0] wb_wdata;

            rf_wb_select #(
                .XLEN   (XLEN),
                .AW     (AW),
                .NUM_WB (NUM_WB)
            ) u_wb_sel (
                .wb_valid   (wb_valid),
                .wb_addr    (wb_addr),
                .wb_data    (wb_data),
                .match_addr (AW'(r)),
                .hit        (wb_hit),
                .data       (wb_wdata)
            );

            assign regs_d[r] = wb_hit ? wb_wdata : regs_q[r];
            // A same-cycle reservation beats the clear: the new owner is still pending.
            assign busy_d[r] = (iss_valid && (iss_rd == AW'(r))) ? 1'b1 :
                               wb_hit                            ? 1'b0 : busy_q[r];
        end
    end

    for (genvar p = 0; p < int'(NUM_RD); p++) begin : g_rd
        logic [AW-1:0]   addr;
        logic            byp_hit;
        logic [XLEN-1:0] byp_data;
        logic            use_byp;

        assign addr = rd_addr[p*AW +: AW];

        rf_wb_select #(
            .XLEN   (XLEN),
            .AW     (AW),
            .NUM_WB (NUM_WB)
        ) u_byp_sel (
            .wb_valid   (wb_valid),
            .wb_addr    (wb_addr),
            .wb_data    (wb_data),
            .match_addr (addr),
            .hit        (byp_hit),
            .data       (byp_data)
        );

        assign use_byp = (BYPASS != 0) && byp_hit;

        assign rd_data[p*XLEN +: XLEN] = (rst || (addr == '0)) ? '0       :
                                         use_byp               ? byp_data : regs_q[addr];
        assign rd_busy[p] = !rst && (addr != '0) && busy_q[addr] && !use_byp;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '0;
            busy_q <= '0;
            snap_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            snap_q <= regs_q;
        end
    end

    assign busy_vec       = busy_q;
    assign o_reg_difftest = snap_q;

endmodule
